// File: rtl/im_instr_encoder_pkg.sv
// Shared MIPS P5-subset constants: class codes, opcodes, functs and loader FSM states.
package im_instr_encoder_pkg;

    typedef enum logic [3:0] {
        CLS_ADDU = 4'd0,
        CLS_SUBU = 4'd1,
        CLS_LW   = 4'd2,
        CLS_SW   = 4'd3,
        CLS_BEQ  = 4'd4,
        CLS_LUI  = 4'd5,
        CLS_JAL  = 4'd6,
        CLS_JR   = 4'd7,
        CLS_ORI  = 4'd8,
        CLS_J    = 4'd9,
        CLS_CMCO = 4'd10
    } instr_class_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_CMCO  = 6'b111011;

    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_JR    = 6'b001000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FULL,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/im_instr_encoder_if.sv
// Command handshake plus instruction-memory write bus between a command source and the encoder.
interface im_instr_encoder_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [3:0]  cmd_class;
    logic [4:0]  cmd_rs;
    logic [4:0]  cmd_rt;
    logic [4:0]  cmd_rd;
    logic [25:0] cmd_imm;
    logic        im_we;
    logic [31:0] im_addr;
    logic [31:0] im_wdata;

    modport master (
        output cmd_valid, cmd_class, cmd_rs, cmd_rt, cmd_rd, cmd_imm,
        input  cmd_ready, im_we, im_addr, im_wdata
    );

    modport slave (
        input  cmd_valid, cmd_class, cmd_rs, cmd_rt, cmd_rd, cmd_imm,
        output cmd_ready, im_we, im_addr, im_wdata
    );
endinterface

// File: rtl/im_instr_encoder_mips_instr_enc.sv
// Combinational (class, fields) -> 32-bit machine word; fields a class does not use are zeroed.
module mips_instr_enc
    import im_instr_encoder_pkg::*;
(
    input  logic [3:0]  cls,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [25:0] imm,
    output logic [31:0] word,
    output logic        legal
);
    always_comb begin
        word  = '0;
        legal = 1'b1;
        case (cls)
            CLS_ADDU: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_ADDU};
            CLS_SUBU: word = {OP_RTYPE, rs, rt, rd, 5'b0, FN_SUBU};
            CLS_JR:   word = {OP_RTYPE, rs, 5'b0, 5'b0, 5'b0, FN_JR};
            CLS_LW:   word = {OP_LW,  rs, rt, imm[15:0]};
            CLS_SW:   word = {OP_SW,  rs, rt, imm[15:0]};
            CLS_BEQ:  word = {OP_BEQ, rs, rt, imm[15:0]};
            CLS_ORI:  word = {OP_ORI, rs, rt, imm[15:0]};
            CLS_LUI:  word = {OP_LUI, 5'b0, rt, imm[15:0]};
            CLS_J:    word = {OP_J,   imm};
            CLS_JAL:  word = {OP_JAL, imm};
            CLS_CMCO: word = {OP_CMCO, rs, rt, rd, 11'b0};
            default:  legal = 1'b0;
        endcase
    end
endmodule

// File: rtl/im_instr_encoder.sv
// Program loader: encodes commands and writes them to consecutive IM words from BASE.
//   state | meaning
//   IDLE  | no session open, commands refused
//   LOAD  | session open, accepting commands while word_cnt < DEPTH
//   FULL  | DEPTH words written, commands refused until finish/start
//   DONE  | session closed by finish
//   ERR   | illegal class accepted, sticky until start/reset
module im_instr_encoder
    import im_instr_encoder_pkg::*;
#(
    parameter logic [31:0] BASE   = 32'h0000_3000,
    parameter int          DEPTH  = 1024,
    parameter int          ADDR_W = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic                finish,
    im_instr_encoder_if.slave   bus,
    output logic [ADDR_W:0]     word_cnt,
    output logic                done,
    output logic                err
);
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

    state_e      state, state_nxt;
    logic        accept;
    logic        legal;
    logic [31:0] word;

    mips_instr_enc u_enc (
        .cls   (bus.cmd_class),
        .rs    (bus.cmd_rs),
        .rt    (bus.cmd_rt),
        .rd    (bus.cmd_rd),
        .imm   (bus.cmd_imm),
        .word  (word),
        .legal (legal)
    );

    assign bus.cmd_ready = (state == ST_LOAD) && (word_cnt < DEPTH_C);
    assign accept        = bus.cmd_valid && bus.cmd_ready;
    assign done          = (state == ST_DONE);
    assign err           = (state == ST_ERR);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOAD: begin
                if (accept && !legal)
                    state_nxt = ST_ERR;
                else if (finish)
                    state_nxt = ST_DONE;
                else if (accept && (word_cnt == DEPTH_C - 1'b1))
                    state_nxt = ST_FULL;
            end
            ST_FULL: if (finish) state_nxt = ST_DONE;
            default: state_nxt = state;
        endcase
        if (start)
            state_nxt = ST_LOAD;
    end

    // A write accepted alongside start still issues; only the index restarts.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            word_cnt     <= '0;
            bus.im_we    <= 1'b0;
            bus.im_addr  <= BASE;
            bus.im_wdata <= '0;
        end else begin
            state     <= state_nxt;
            bus.im_we <= accept && legal;
            if (accept && legal) begin
                bus.im_addr  <= BASE + 32'({word_cnt, 2'b00});
                bus.im_wdata <= word;
            end
            if (start)
                word_cnt <= '0;
            else if (accept && legal)
                word_cnt <= word_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_im_instr_encoder.sv
// Scoreboard bench for im_instr_encoder: directed MIPS encodings plus randomized load sessions.
module tb_im_instr_encoder;
    localparam logic [31:0] BASE   = 32'h0000_3000;
    localparam int          DEPTH  = 4;
    localparam int          ADDR_W = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              finish;
    logic [ADDR_W:0]   word_cnt;
    logic              done;
    logic              err;

    im_instr_encoder_if bus ();

    im_instr_encoder #(.BASE(BASE), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .finish   (finish),
        .bus      (bus),
        .word_cnt (word_cnt),
        .done     (done),
        .err      (err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          model_idx = 0;
    logic [63:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference encoding built from field weights (bit position n -> 2**n).
    function automatic logic [31:0] ref_enc(input int cls, input logic [31:0] rs, input logic [31:0] rt,
                                            input logic [31:0] rd, input logic [31:0] imm);
        logic [31:0] i16, i26;
        i16 = imm % 32'd65536;
        i26 = imm % 32'd67108864;
        case (cls)
            0:  return rs * 2**21 + rt * 2**16 + rd * 2**11 + 33;
            1:  return rs * 2**21 + rt * 2**16 + rd * 2**11 + 35;
            2:  return 35 * 2**26 + rs * 2**21 + rt * 2**16 + i16;
            3:  return 43 * 2**26 + rs * 2**21 + rt * 2**16 + i16;
            4:  return 4 * 2**26 + rs * 2**21 + rt * 2**16 + i16;
            5:  return 15 * 2**26 + rt * 2**16 + i16;
            6:  return 3 * 2**26 + i26;
            7:  return rs * 2**21 + 8;
            8:  return 13 * 2**26 + rs * 2**21 + rt * 2**16 + i16;
            9:  return 2 * 2**26 + i26;
            10: return 59 * 2**26 + rs * 2**21 + rt * 2**16 + rd * 2**11;
            default: return 32'h0;
        endcase
    endfunction

    // Called at a negedge; returns at the negedge before the accepting posedge.
    task automatic send(input logic [3:0] c, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [25:0] imm, input logic [31:0] exp_word);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_class = c;
        bus.cmd_rs    = rs;
        bus.cmd_rt    = rt;
        bus.cmd_rd    = rd;
        bus.cmd_imm   = imm;
        while (!bus.cmd_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!bus.cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: cmd_ready=0 after %0d cycles, required 1", n);
            bus.cmd_valid = 1'b0;
            return;
        end
        if (c <= 4'd10) begin
            exp_q.push_back({BASE + 32'(model_idx) * 4, exp_word});
            model_idx++;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        model_idx = 0;
    endtask

    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            if (bus.im_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: im_we=1 addr 0x%08h data 0x%08h, required no write",
                             bus.im_addr, bus.im_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("im_addr", bus.im_addr, e[63:32]);
                    check("im_wdata", bus.im_wdata, e[31:0]);
                end
            end
        end
    end

    initial begin
        reset = 1'b1; start = 1'b0; finish = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_class = '0; bus.cmd_rs = '0;
        bus.cmd_rt = '0; bus.cmd_rd = '0; bus.cmd_imm = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(bus.cmd_ready), 0);
        check("rst_we", 32'(bus.im_we), 0);
        check("rst_addr", bus.im_addr, BASE);
        check("rst_wdata", bus.im_wdata, 0);
        check("rst_cnt", 32'(word_cnt), 0);
        check("rst_done_err", {30'b0, done, err}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_ready", 32'(bus.cmd_ready), 0);

        // addu rs1 rt2 rd3
        pulse_start();
        check("load_ready", 32'(bus.cmd_ready), 1);
        send(4'd0, 5'd1, 5'd2, 5'd3, 26'd0, 32'h0022_1821);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("cnt_after_addu", 32'(word_cnt), 1);

        // ori then lw back to back, then jal, jr (rd forced 0) reaching DEPTH
        pulse_start();
        send(4'd8, 5'd0, 5'd8, 5'd0, 26'h1234, 32'h3408_1234);
        @(negedge clk);
        send(4'd2, 5'd0, 5'd9, 5'd0, 26'h4, 32'h8C09_0004);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("cnt_two", 32'(word_cnt), 2);
        send(4'd6, 5'd0, 5'd0, 5'd0, 26'h0C00, 32'h0C00_0C00);
        @(negedge clk);
        send(4'd7, 5'd31, 5'd0, 5'd5, 26'h0, 32'h03E0_0008);
        @(negedge clk);
        check("full_ready", 32'(bus.cmd_ready), 0);
        check("full_cnt", 32'(word_cnt), DEPTH);
        repeat (3) @(negedge clk);
        bus.cmd_valid = 1'b0;
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        check("full_done", 32'(done), 1);
        check("full_cnt_held", 32'(word_cnt), DEPTH);

        // illegal class
        pulse_start();
        check("restart_done", 32'(done), 0);
        send(4'hF, 5'd1, 5'd1, 5'd1, 26'd1, 32'h0);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        check("illegal_err", 32'(err), 1);
        check("illegal_ready", 32'(bus.cmd_ready), 0);
        check("illegal_we", 32'(bus.im_we), 0);
        pulse_start();
        check("clr_err", 32'(err), 0);
        check("clr_cnt", 32'(word_cnt), 0);
        check("clr_ready", 32'(bus.cmd_ready), 1);

        // accept together with finish
        send(4'd10, 5'd4, 5'd5, 5'd6, 26'd0, 32'hEC85_3000);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        bus.cmd_valid = 1'b0;
        check("accfin_done", 32'(done), 1);
        check("accfin_cnt", 32'(word_cnt), 1);

        // start and finish together: start wins
        start = 1'b1; finish = 1'b1;
        @(negedge clk);
        start = 1'b0; finish = 1'b0; model_idx = 0;
        check("stfin_done", 32'(done), 0);
        check("stfin_ready", 32'(bus.cmd_ready), 1);

        // randomized sessions against the reference model
        for (int s = 0; s < 8; s++) begin
            int n;
            pulse_start();
            n = $urandom_range(0, 6);
            for (int k = 0; k < n; k++) begin
                if (model_idx < DEPTH) begin
                    int          c;
                    logic [4:0]  rs, rt, rd;
                    logic [25:0] imm;
                    c   = $urandom_range(0, 10);
                    rs  = 5'($urandom);
                    rt  = 5'($urandom);
                    rd  = 5'($urandom);
                    imm = 26'($urandom);
                    send(4'(c), rs, rt, rd, imm, ref_enc(c, 32'(rs), 32'(rt), 32'(rd), 32'(imm)));
                    @(negedge clk);
                    bus.cmd_valid = 1'b0;
                    repeat ($urandom_range(0, 1)) @(negedge clk);
                end else begin
                    bus.cmd_valid = 1'b1;
                    check("rand_full_ready", 32'(bus.cmd_ready), 0);
                    @(negedge clk);
                    bus.cmd_valid = 1'b0;
                end
            end
            check("rand_cnt", 32'(word_cnt), 32'(model_idx));
            finish = 1'b1;
            @(negedge clk);
            finish = 1'b0;
            check("rand_done", 32'(done), 1);
        end

        // reset while a write is being presented
        pulse_start();
        send(4'd0, 5'd7, 5'd7, 5'd7, 26'd0, 32'h00E7_3821);
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        reset = 1'b1;
        #1;
        exp_q.delete();
        check("rstmid_we", 32'(bus.im_we), 0);
        check("rstmid_addr", bus.im_addr, BASE);
        check("rstmid_wdata", bus.im_wdata, 0);
        check("rstmid_cnt", 32'(word_cnt), 0);
        check("rstmid_ready", 32'(bus.cmd_ready), 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
